uart_tx_port: RTL and testbench



---
 rtl/uart_tx_port.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_port
// Purpose  : Byte-wide serial output port. Processor writes land in a small
//            FIFO through a single-cycle strobe. A transmitter FSM drains the
//            FIFO and sends each byte as an asynchronous 8N1 frame on tx,
//            LSB first, with no idle gap between back-to-back frames.
// Ports    : clk    - clock, rising edge active
//            reset  - asynchronous, active-high reset
//            we     - write strobe (one byte per cycle it is high)
//            wd     - write data
//            full   - FIFO holds DEPTH entries
//            empty  - FIFO holds no entries
//            busy   - transmitter is not idle
//            ovf    - sticky flag: a write arrived while the FIFO was full
//            tx     - serial line, idle high
// Params   : CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//            DEPTH        - FIFO entries (power of two, >= 2)
// Macro    : UART_TX_PARITY_EN - when defined, an even-parity bit is sent
//            between the data bits and the stop bit (11-bit frame).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wd,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  output logic       tx
);

  // Pointer width and baud counter width.
  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_bw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(DEPTH);
  localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      c_last_bit  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_count;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_head;

  assign full   = (r_count == c_depth);
  assign empty  = (r_count == '0);
  // Fullness is judged on the pre-edge count, so a write on a full FIFO is
  // dropped even when the transmitter pops on the same edge.
  assign w_push = we & ~full;
  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (we && full) begin
      ovf <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  state_t        r_state;
  logic [c_bw-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_baud_last;
  logic [2:0]    w_next_bit;

  assign w_baud_last = (r_baud == c_baud_last);
  assign w_next_bit  = r_bit + 3'd1;
  assign busy        = (r_state != S_IDLE);

  // The FIFO pop happens either from IDLE, or on the final cycle of the stop
  // bit so the next start bit follows without an idle gap.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = ~empty;
      S_STOP:  w_pop = w_baud_last & ~empty;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          tx     <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            tx      <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_bit   <= '0;
            tx      <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + c_bw'(1);
          end
        end

        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
              tx      <= ^r_shift;
              r_state <= S_PARITY;
`else
              tx      <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= w_next_bit;
              tx    <= r_shift[w_next_bit];
            end
          end else begin
            r_baud <= r_baud + c_bw'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            tx      <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + c_bw'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            r_bit  <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              tx      <= 1'b0;
              r_state <= S_START;
            end else begin
              tx      <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + c_bw'(1);
          end
        end

        default: begin
          tx      <= 1'b1;
          r_baud  <= '0;
          r_bit   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_port
// Purpose  : Self-checking bench for uart_tx_port. Writes are scored against a
//            timing model of the port (FIFO occupancy and frame start edges
//            derived from write edges); a line monitor decodes tx frames and
//            compares them with the expected queue. Honours UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * C;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       we    = 1'b0;
  logic [7:0] wd    = 8'h00;
  logic       full, empty, busy, ovf, tx;

  uart_tx_port #(.CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wd    (wd),
    .full  (full),
    .empty (empty),
    .busy  (busy),
    .ovf   (ovf),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge it names the last edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each accepted byte has an accept edge and a pop edge.
  // A byte popped at edge p starts its frame at p; the next pop is the later
  // of (accept edge + 1) and the end of the previous frame.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  int   m_acc[$];
  int   m_pop[$];
  exp_t sb_q[$];
  int   m_last_pop = -1000000;
  int   m_ovf_t    = -1;

  // FIFO occupancy just after edge n.
  function automatic int model_count(input int n);
    int c = 0;
    foreach (m_acc[i]) if (m_acc[i] <= n && m_pop[i] > n) c++;
    return c;
  endfunction

  function automatic logic model_busy(input int n);
    foreach (m_pop[i]) if (m_pop[i] <= n && n < m_pop[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input int t, input logic [7:0] d);
    int   p;
    exp_t e;
    if (model_count(t - 1) < DEPTH) begin
      p = (t + 1 > m_last_pop + FRAME) ? t + 1 : m_last_pop + FRAME;
      m_acc.push_back(t);
      m_pop.push_back(p);
      e.data  = d;
      e.start = p;
      sb_q.push_back(e);
      m_last_pop = p;
    end else if (m_ovf_t < 0) begin
      m_ovf_t = t;
    end
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_pop.delete();
    sb_q.delete();
    m_last_pop = -1000000;
    m_ovf_t    = -1;
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge.
  task automatic do_write(input logic [7:0] d);
    we = 1'b1;
    wd = d;
    model_write(cyc + 1, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    wait_until(m_last_pop + FRAME + 2);
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle status checks against the model.
  // ---------------------------------------------------------------------------
  int chk_cnt;
  initial begin : status_checker
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk_cnt = model_count(cyc);
        check("empty", empty, (chk_cnt == 0));
        check("full", full, (chk_cnt == DEPTH));
        check("busy", busy, model_busy(cyc));
        check("ovf", ovf, (m_ovf_t >= 0 && m_ovf_t <= cyc));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line monitor: decodes each frame, pops the scoreboard and compares.
  // ---------------------------------------------------------------------------
  int          mon_s;
  logic [NB-1:0] mon_bits;
  logic        mon_stable;
  logic        mon_abort;
  exp_t        mon_e;
  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (!reset && tx == 1'b0) begin
        mon_s      = cyc;
        mon_bits   = '0;
        mon_stable = 1'b1;
        mon_abort  = 1'b0;
        for (int j = 0; j < FRAME; j++) begin
          if (j > 0) @(negedge clk);
          if (reset) begin
            mon_abort = 1'b1;
            break;
          end
          if (j % C == 0) mon_bits[j / C] = tx;
          else if (tx !== mon_bits[j / C]) mon_stable = 1'b0;
        end
        if (!mon_abort) begin
          if (sb_q.size() == 0) begin
            check("unexpected frame", 1, 0);
          end else begin
            mon_e = sb_q.pop_front();
            check("frame data", mon_bits[8:1], mon_e.data);
            check("frame start edge", mon_s, mon_e.start);
            check("stop bit", mon_bits[NB-1], 1);
            check("bit stability", mon_stable, 1);
`ifdef UART_TX_PARITY_EN
            check("parity bit", mon_bits[9], ^mon_e.data);
`endif
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int e_end;
  initial begin : stim
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset empty", empty, 1);
    check("reset full", full, 0);
    check("reset ovf", ovf, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte, then back-to-back pair, then parity-sensitive bytes.
    do_write(8'hA5);
    drain();
    do_write(8'h00);
    do_write(8'hFF);
    drain();
    do_write(8'h07);
    do_write(8'h03);
    drain();

    // Overflow while the transmitter is busy.
    do_write(8'h55);
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 5; i++) do_write(8'(i));
    check("ovf after overflow", ovf, 1);
    drain();

    // Write on a full FIFO on the same edge as the stop-final pop.
    do_write(8'h10);
    e_end = m_last_pop + FRAME;
    for (int i = 0; i < 4; i++) do_write(8'(8'h11 + i));
    wait_until(e_end - 1);
    do_write(8'h77);
    check("full after full+pop edge", full, 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) do_write(8'($urandom));
      else @(negedge clk);
    end
    drain();

    // Asynchronous reset in the middle of a frame with bytes queued.
    for (int i = 0; i < 6; i++) do_write(8'(8'hC0 + i));
    repeat (10) @(negedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid-frame reset tx", tx, 1);
    check("mid-frame reset busy", busy, 0);
    check("mid-frame reset empty", empty, 1);
    check("mid-frame reset ovf", ovf, 0);
    check("mid-frame reset full", full, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    // Port still works after reset.
    do_write(8'h81);
    drain();

    check("scoreboard drained", sb_q.size(), 0);
    check("final busy", busy, 0);
    check("final empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
